// File: rtl/rsa_seq_ctrl.sv
// rsa_seq_ctrl: launch/run/capture sequencer for the 8-bit RSA core.
// Snapshots operands, gates core reset/enable, watches eoc, reports status.
module rsa_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             clr_status,
    input  logic [WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0] e_i,
    input  logic [WIDTH-1:0] m_i,
    input  logic [WIDTH-1:0] const_i,
    output logic             rsa_rst_n,
    output logic             rsa_en,
    output logic [WIDTH-1:0] rsa_p,
    output logic [WIDTH-1:0] rsa_e,
    output logic [WIDTH-1:0] rsa_m,
    output logic [WIDTH-1:0] rsa_const,
    input  logic             rsa_eoc,
    input  logic [WIDTH-1:0] rsa_c,
    output logic [WIDTH-1:0] result,
    output logic             result_vld,
    output logic [7:0]       status
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             busy;
    logic             done;
    logic             err_timeout;
    logic             err_busy;
    logic             err_param;
    logic [CNT_W-1:0] wdog;

    assign status = {3'b000, err_param, err_busy, err_timeout, busy, done};

    // Sequencer FSM; flag sets are written after clr_status so a set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            rsa_rst_n   <= 1'b0;
            rsa_en      <= 1'b0;
            rsa_p       <= '0;
            rsa_e       <= '0;
            rsa_m       <= '0;
            rsa_const   <= '0;
            result      <= '0;
            result_vld  <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_busy    <= 1'b0;
            err_param   <= 1'b0;
            wdog        <= '0;
        end else begin
            result_vld <= 1'b0;
            if (clr_status) begin
                done        <= 1'b0;
                err_timeout <= 1'b0;
                err_busy    <= 1'b0;
                err_param   <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (m_i != '0) begin
                            rsa_p     <= p_i;
                            rsa_e     <= e_i;
                            rsa_m     <= m_i;
                            rsa_const <= const_i;
                            done      <= 1'b0;
                            rsa_rst_n <= 1'b1;
                            busy      <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            err_param <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (start)
                        err_busy <= 1'b1;
                    if (abort) begin
                        rsa_rst_n <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        rsa_en <= 1'b1;
                        wdog   <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (start)
                        err_busy <= 1'b1;
                    if (abort) begin
                        rsa_rst_n <= 1'b0;
                        rsa_en    <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (rsa_eoc) begin
                        result     <= rsa_c;
                        result_vld <= 1'b1;
                        done       <= 1'b1;
                        rsa_rst_n  <= 1'b0;
                        rsa_en     <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (wdog == WD_LAST) begin
                        err_timeout <= 1'b1;
                        rsa_rst_n   <= 1'b0;
                        rsa_en      <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    rsa_rst_n <= 1'b0;
                    rsa_en    <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// tb_rsa_seq_ctrl: directed bench for rsa_seq_ctrl.
// Main instance uses defaults; a second one uses TIMEOUT=16.
module tb_rsa_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       clr_status = 1'b0;
    logic [7:0] p_i = 8'h00;
    logic [7:0] e_i = 8'h00;
    logic [7:0] m_i = 8'h00;
    logic [7:0] const_i = 8'h00;
    logic       rsa_eoc = 1'b0;
    logic [7:0] rsa_c = 8'h00;

    logic       rsa_rst_n, rsa_en, result_vld;
    logic [7:0] rsa_p, rsa_e, rsa_m, rsa_const, result, status;

    logic       rsa_rst_n2, rsa_en2, result_vld2;
    logic [7:0] rsa_p2, rsa_e2, rsa_m2, rsa_const2, result2, status2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rsa_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .clr_status(clr_status), .p_i(p_i), .e_i(e_i), .m_i(m_i),
        .const_i(const_i), .rsa_rst_n(rsa_rst_n), .rsa_en(rsa_en),
        .rsa_p(rsa_p), .rsa_e(rsa_e), .rsa_m(rsa_m),
        .rsa_const(rsa_const), .rsa_eoc(rsa_eoc), .rsa_c(rsa_c),
        .result(result), .result_vld(result_vld), .status(status)
    );

    rsa_seq_ctrl #(.WIDTH(8), .TIMEOUT(16), .CNT_W(5)) dut_t (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .clr_status(clr_status), .p_i(p_i), .e_i(e_i), .m_i(m_i),
        .const_i(const_i), .rsa_rst_n(rsa_rst_n2), .rsa_en(rsa_en2),
        .rsa_p(rsa_p2), .rsa_e(rsa_e2), .rsa_m(rsa_m2),
        .rsa_const(rsa_const2), .rsa_eoc(rsa_eoc), .rsa_c(rsa_c),
        .result(result2), .result_vld(result_vld2), .status(status2)
    );

    typedef struct {
        logic       st;
        logic       ab;
        logic       cl;
        logic [7:0] m;
        logic       eoc;
        logic [7:0] c;
        logic [7:0] x_status;
        logic       x_en;
        logic       x_rstn;
        logic       x_vld;
        logic [7:0] x_result;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #2;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic launch(input logic [7:0] m);
        m_i   = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic vacc;

    initial begin
        // stimulus table: start abort clr m eoc c | status en rstn vld result
        vt[0]  = '{1, 0, 0, 8'h00, 0, 8'h00, 8'h10, 0, 0, 0, 8'h00};
        vt[1]  = '{0, 0, 1, 8'h02, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00};
        vt[2]  = '{1, 0, 0, 8'h02, 0, 8'h00, 8'h02, 0, 1, 0, 8'h00};
        vt[3]  = '{0, 0, 0, 8'h02, 0, 8'h00, 8'h02, 1, 1, 0, 8'h00};
        vt[4]  = '{1, 0, 0, 8'h02, 0, 8'h00, 8'h0A, 1, 1, 0, 8'h00};
        vt[5]  = '{0, 0, 0, 8'h02, 1, 8'h3C, 8'h09, 0, 0, 1, 8'h3C};
        vt[6]  = '{0, 0, 0, 8'h02, 0, 8'h00, 8'h09, 0, 0, 0, 8'h3C};
        vt[7]  = '{0, 0, 0, 8'h02, 1, 8'h55, 8'h09, 0, 0, 0, 8'h3C};
        vt[8]  = '{1, 0, 1, 8'h05, 0, 8'h00, 8'h02, 0, 1, 0, 8'h3C};
        vt[9]  = '{0, 0, 0, 8'h05, 0, 8'h00, 8'h02, 1, 1, 0, 8'h3C};
        vt[10] = '{0, 1, 0, 8'h05, 1, 8'h77, 8'h00, 0, 0, 0, 8'h3C};
        vt[11] = '{0, 1, 0, 8'h05, 0, 8'h00, 8'h00, 0, 0, 0, 8'h3C};
        vt[12] = '{1, 0, 0, 8'h03, 0, 8'h00, 8'h02, 0, 1, 0, 8'h3C};
        vt[13] = '{0, 1, 0, 8'h03, 0, 8'h00, 8'h00, 0, 0, 0, 8'h3C};
        vt[14] = '{1, 0, 0, 8'h01, 0, 8'h00, 8'h02, 0, 1, 0, 8'h3C};
        vt[15] = '{0, 0, 0, 8'h01, 0, 8'h00, 8'h02, 1, 1, 0, 8'h3C};
        vt[16] = '{1, 0, 1, 8'h01, 0, 8'h00, 8'h0A, 1, 1, 0, 8'h3C};
        vt[17] = '{0, 0, 1, 8'h01, 1, 8'h11, 8'h01, 0, 0, 1, 8'h11};

        // reset state
        #3;
        chk("reset status", status, 8'h00);
        chk("reset rsa_rst_n", rsa_rst_n, 1'b0);
        chk("reset rsa_en", rsa_en, 1'b0);
        chk("reset result", result, 8'h00);
        chk("reset result_vld", result_vld, 1'b0);
        chk("reset rsa_m", rsa_m, 8'h00);
        tick();
        rst_n = 1'b1;

        // table-driven sequence
        p_i = 8'h21; e_i = 8'h07; const_i = 8'h1C;
        for (int i = 0; i < 18; i++) begin
            start      = vt[i].st;
            abort      = vt[i].ab;
            clr_status = vt[i].cl;
            m_i        = vt[i].m;
            rsa_eoc    = vt[i].eoc;
            rsa_c      = vt[i].c;
            tick();
            start = 0; abort = 0; clr_status = 0; rsa_eoc = 0;
            chk($sformatf("vec%0d status", i), status, vt[i].x_status);
            chk($sformatf("vec%0d rsa_en", i), rsa_en, vt[i].x_en);
            chk($sformatf("vec%0d rsa_rst_n", i), rsa_rst_n, vt[i].x_rstn);
            chk($sformatf("vec%0d result_vld", i), result_vld, vt[i].x_vld);
            chk($sformatf("vec%0d result", i), result, vt[i].x_result);
        end

        // normal run, eoc on the 20th RUN cycle, operand freeze
        do_reset();
        p_i = 8'h21; e_i = 8'h07; const_i = 8'h1C;
        launch(8'h02);
        chk("run load status", status, 8'h02);
        chk("run load rsa_en", rsa_en, 1'b0);
        chk("run load rsa_rst_n", rsa_rst_n, 1'b1);
        tick();
        chk("run rsa_en", rsa_en, 1'b1);
        chk("run rsa_p", rsa_p, 8'h21);
        chk("run rsa_e", rsa_e, 8'h07);
        chk("run rsa_m", rsa_m, 8'h02);
        chk("run rsa_const", rsa_const, 8'h1C);
        p_i = 8'hFF; m_i = 8'h00;
        for (int i = 1; i < 20; i++) tick();
        chk("run busy before eoc", status, 8'h02);
        chk("run frozen rsa_p", rsa_p, 8'h21);
        rsa_eoc = 1'b1; rsa_c = 8'h1D;
        tick();
        rsa_eoc = 1'b0;
        chk("run result", result, 8'h1D);
        chk("run result_vld", result_vld, 1'b1);
        chk("run status", status, 8'h01);
        tick();
        chk("run result_vld one cycle", result_vld, 1'b0);

        // timeout on the TIMEOUT=16 instance
        do_reset();
        p_i = 8'h21;
        launch(8'h02);
        tick();
        vacc = result_vld2;
        for (int i = 1; i < 16; i++) begin
            tick();
            vacc |= result_vld2;
        end
        chk("tmo busy at 15", status2, 8'h02);
        tick();
        vacc |= result_vld2;
        chk("tmo status", status2, 8'h04);
        chk("tmo rsa_rst_n", rsa_rst_n2, 1'b0);
        chk("tmo rsa_en", rsa_en2, 1'b0);
        chk("tmo no result_vld", vacc, 1'b0);

        // abort on the 10th RUN cycle
        do_reset();
        launch(8'h02);
        tick();
        vacc = 1'b0;
        for (int i = 1; i < 10; i++) begin
            tick();
            vacc |= result_vld;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vacc |= result_vld;
        chk("abort status", status, 8'h00);
        chk("abort rsa_rst_n", rsa_rst_n, 1'b0);
        chk("abort rsa_en", rsa_en, 1'b0);
        chk("abort no result_vld", vacc, 1'b0);

        // async reset mid-run, then relaunch
        p_i = 8'h21;
        launch(8'h02);
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("areset rsa_rst_n", rsa_rst_n, 1'b0);
        chk("areset rsa_en", rsa_en, 1'b0);
        chk("areset status", status, 8'h00);
        chk("areset rsa_p", rsa_p, 8'h00);
        #1 rst_n = 1'b1;
        tick();
        p_i = 8'h44;
        launch(8'h09);
        chk("relaunch status", status, 8'h02);
        tick();
        chk("relaunch rsa_en", rsa_en, 1'b1);
        chk("relaunch rsa_p", rsa_p, 8'h44);
        chk("relaunch rsa_m", rsa_m, 8'h09);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
